// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream boot loader that fills PicoBlaze program RAM and gates cpu_reset
module prog_loader #(
    parameter int          MEM_DEPTH = 1024,
    parameter int          TIMEOUT   = 1000000,
    parameter bit          BOOT_HOLD = 1'b0,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [9:0]  mem_addr,
    output logic [17:0] mem_data,
    output logic [3:0]  mem_we,
    output logic        load_active,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2, S_CSUM
    } state_t;

    state_t        state, state_n;
    logic [7:0]    len_hi_q;
    logic [10:0]   len_q;
    logic [10:0]   wcnt;
    logic [1:0]    b0_q;
    logic [7:0]    b1_q;
    logic [7:0]    csum;
    logic [TW-1:0] tcnt;

    logic          timeout_hit;
    logic          take;
    logic [10:0]   len_in;
    logic          len_bad;
    logic          last_word;
    logic          sum_ok;
    logic          ev_start, ev_write, ev_good, ev_abort;

    // Expiry is independent of rx_valid so a byte landing on the expiry cycle is dropped.
    assign timeout_hit = (TIMEOUT != 0) && (state != S_IDLE) && (tcnt == TW'(TLIM));
    assign take        = rx_valid && !timeout_hit;
    assign len_in      = {len_hi_q[2:0], rx_data};
    assign len_bad     = (len_hi_q[7:3] != 5'd0) || ({21'd0, len_in} > 32'(MEM_DEPTH));
    assign last_word   = (11'(wcnt + 11'd1) == len_q);
    assign sum_ok      = (8'(csum + rx_data) == 8'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (timeout_hit) begin
            state_n = S_IDLE;
        end else if (rx_valid) begin
            case (state)
                S_IDLE:   if (rx_data == SYNC_BYTE) state_n = S_LEN_HI;
                S_LEN_HI: state_n = S_LEN_LO;
                S_LEN_LO: begin
                    if (len_bad)              state_n = S_IDLE;
                    else if (len_in == 11'd0) state_n = S_CSUM;
                    else                      state_n = S_B0;
                end
                S_B0:     state_n = S_B1;
                S_B1:     state_n = S_B2;
                S_B2:     state_n = last_word ? S_CSUM : S_B0;
                S_CSUM:   state_n = S_IDLE;
                default:  state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ev_start = 1'b0;
        ev_write = 1'b0;
        ev_good  = 1'b0;
        ev_abort = 1'b0;
        if (timeout_hit) begin
            ev_abort = 1'b1;
        end else if (rx_valid) begin
            case (state)
                S_IDLE:   ev_start = (rx_data == SYNC_BYTE);
                S_LEN_LO: ev_abort = len_bad;
                S_B2:     ev_write = 1'b1;
                S_CSUM: begin
                    ev_good  = sum_ok;
                    ev_abort = !sum_ok;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr    <= '0;
            mem_data    <= '0;
            mem_we      <= 4'h0;
            load_active <= 1'b0;
            cpu_reset   <= BOOT_HOLD;
            done        <= 1'b0;
            error       <= 1'b0;
            len_hi_q    <= '0;
            len_q       <= '0;
            wcnt        <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            csum        <= '0;
            tcnt        <= '0;
        end else begin
            mem_we <= 4'h0;
            if (mem_we != 4'h0) mem_addr <= 10'(mem_addr + 10'd1);

            if (state == S_IDLE || rx_valid || timeout_hit) tcnt <= '0;
            else if (TIMEOUT != 0)                          tcnt <= TW'(tcnt + 1'b1);

            if (take && state != S_IDLE) csum <= 8'(csum + rx_data);
            if (take && state == S_LEN_HI) len_hi_q <= rx_data;
            if (take && state == S_LEN_LO) len_q    <= len_in;
            if (take && state == S_B0)     b0_q     <= rx_data[1:0];
            if (take && state == S_B1)     b1_q     <= rx_data;

            if (ev_start) begin
                load_active <= 1'b1;
                cpu_reset   <= 1'b1;
                done        <= 1'b0;
                error       <= 1'b0;
                csum        <= '0;
                wcnt        <= '0;
                mem_addr    <= '0;
            end
            if (ev_write) begin
                mem_data <= {b0_q, b1_q, rx_data};
                mem_we   <= 4'hF;
                wcnt     <= 11'(wcnt + 11'd1);
            end
            if (ev_good) begin
                done        <= 1'b1;
                load_active <= 1'b0;
                cpu_reset   <= 1'b0;
            end
            // cpu_reset is left asserted: the RAM holds a partial image.
            if (ev_abort) begin
                error       <= 1'b1;
                load_active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [9:0]  mem_addr;
    logic [17:0] mem_data;
    logic [3:0]  mem_we;
    logic        load_active;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    int          wr_n = 0;
    logic [9:0]  wr_addr[64];
    logic [17:0] wr_data[64];
    logic [3:0]  wr_we[64];

    prog_loader #(
        .MEM_DEPTH (1024),
        .TIMEOUT   (16),
        .BOOT_HOLD (1'b0),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_we      (mem_we),
        .load_active (load_active),
        .cpu_reset   (cpu_reset),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we != 4'h0 && wr_n < 64) begin
            wr_addr[wr_n] = mem_addr;
            wr_data[wr_n] = mem_data;
            wr_we[wr_n]   = mem_we;
            wr_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input bq_t f, input int gap);
        foreach (f[i]) send(f[i], (i == f.size() - 1) ? 0 : gap);
    endtask

    task automatic check_word(input string tag, input int idx, input logic [9:0] a, input logic [17:0] d);
        check({tag, "_addr"}, 32'(wr_addr[idx]), 32'(a));
        check({tag, "_data"}, 32'(wr_data[idx]), 32'(d));
        check({tag, "_we"},   32'(wr_we[idx]),   32'h0000_000F);
    endtask

    initial begin
        bq_t f;
        int  base;
        int  k;

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        check("rst_addr",   32'(mem_addr),    32'h0);
        check("rst_data",   32'(mem_data),    32'h0);
        check("rst_we",     32'(mem_we),      32'h0);
        check("rst_active", 32'(load_active), 32'h0);
        check("rst_cpurst", 32'(cpu_reset),   32'h0);
        check("rst_done",   32'(done),        32'h0);
        check("rst_error",  32'(error),       32'h0);

        // Good load with idle gaps between bytes.
        base = wr_n;
        send(8'hA5, 1);
        check("good_active_on_sync", 32'(load_active), 32'h1);
        check("good_cpurst_on_sync", 32'(cpu_reset),   32'h1);
        f = '{8'h00, 8'h02, 8'h03, 8'h0F, 8'h3F, 8'h00, 8'hE0, 8'h00, 8'hCD};
        send_frame(f, 2);
        check("good_done",   32'(done),        32'h1);
        check("good_cpurst", 32'(cpu_reset),   32'h0);
        check("good_error",  32'(error),       32'h0);
        check("good_active", 32'(load_active), 32'h0);
        check("good_nwr",    32'(wr_n - base), 32'd2);
        check_word("good_w0", base,     10'd0, 18'h30F3F);
        check_word("good_w1", base + 1, 10'd1, 18'h0E000);
        check("good_addr_end", 32'(mem_addr), 32'd2);

        // Bad checksum, bytes back to back.
        base = wr_n;
        f = '{8'hA5, 8'h00, 8'h02, 8'h03, 8'h0F, 8'h3F, 8'h00, 8'hE0, 8'h00, 8'hCC};
        send_frame(f, 0);
        check("bad_error",  32'(error),       32'h1);
        check("bad_done",   32'(done),        32'h0);
        check("bad_cpurst", 32'(cpu_reset),   32'h1);
        check("bad_active", 32'(load_active), 32'h0);
        check("bad_nwr",    32'(wr_n - base), 32'd2);
        check_word("bad_w0", base,     10'd0, 18'h30F3F);
        check_word("bad_w1", base + 1, 10'd1, 18'h0E000);

        // Oversize length 0x401, then stray data bytes that must not be loaded.
        base = wr_n;
        f = '{8'hA5, 8'h04, 8'h01};
        send_frame(f, 0);
        check("over_error",  32'(error),       32'h1);
        check("over_active", 32'(load_active), 32'h0);
        f = '{8'h03, 8'h0F, 8'h3F, 8'h00};
        send_frame(f, 0);
        repeat (4) @(posedge clk);
        #1;
        check("over_nwr", 32'(wr_n - base), 32'd0);

        // Reserved length bits set.
        f = '{8'hA5, 8'h08, 8'h00};
        send_frame(f, 1);
        check("lenhi_error", 32'(error), 32'h1);

        // Zero length.
        base = wr_n;
        f = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(f, 0);
        check("zero_done",   32'(done),        32'h1);
        check("zero_error",  32'(error),       32'h0);
        check("zero_cpurst", 32'(cpu_reset),   32'h0);
        check("zero_nwr",    32'(wr_n - base), 32'd0);

        // Sync byte value used as data.
        base = wr_n;
        f = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'h10};
        send_frame(f, 0);
        check("sync_done", 32'(done),        32'h1);
        check("sync_nwr",  32'(wr_n - base), 32'd1);
        check_word("sync_w0", base, 10'd0, 18'h1A5A5);

        // Stall after B1.
        base = wr_n;
        f = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h12};
        send_frame(f, 0);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        check("tmo_early_error",  32'(error),       32'h0);
        check("tmo_early_active", 32'(load_active), 32'h1);
        k = 0;
        while (!error && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("tmo_error",  32'(error),       32'h1);
        check("tmo_active", 32'(load_active), 32'h0);
        check("tmo_cpurst", 32'(cpu_reset),   32'h1);
        check("tmo_nwr",    32'(wr_n - base), 32'd0);

        // Reset during the first write pulse.
        base = wr_n;
        f = '{8'hA5, 8'h00, 8'h02, 8'h03, 8'h0F, 8'h3F};
        send_frame(f, 0);
        check("mid_we_pulse", 32'(mem_we), 32'hF);
        reset = 1'b1;
        #1;
        check("mid_rst_we",     32'(mem_we),      32'h0);
        check("mid_rst_addr",   32'(mem_addr),    32'h0);
        check("mid_rst_data",   32'(mem_data),    32'h0);
        check("mid_rst_active", 32'(load_active), 32'h0);
        check("mid_rst_cpurst", 32'(cpu_reset),   32'h0);
        check("mid_rst_done",   32'(done),        32'h0);
        check("mid_rst_error",  32'(error),       32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_nwr", 32'(wr_n - base), 32'd0);
        f = '{8'hA5, 8'h00, 8'h02, 8'h03, 8'h0F, 8'h3F, 8'h00, 8'hE0, 8'h00, 8'hCD};
        send_frame(f, 1);
        check("reload_done",  32'(done),        32'h1);
        check("reload_error", 32'(error),       32'h0);
        check("reload_nwr",   32'(wr_n - base), 32'd2);
        check_word("reload_w0", base,     10'd0, 18'h30F3F);
        check_word("reload_w1", base + 1, 10'd1, 18'h0E000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
